// File: rtl/commit_redirect_sequencer_if.sv
// Commit-to-fetch recovery bundle: retire events in, flush/stall/redirect out.
// master = commit/fetch side, slave = the sequencer.
interface commit_redirect_sequencer_if;
  logic        br_valid;
  logic [31:0] br_target;
  logic        br_ds_done;
  logic        ds_valid;
  logic        exc_valid;
  logic        eret_valid;
  logic [31:0] eret_target;
  logic        commit_stall;
  logic        flush_req;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        busy;

  modport master (
    output br_valid, br_target, br_ds_done, ds_valid,
    output exc_valid, eret_valid, eret_target, redirect_ready,
    input  commit_stall, flush_req, redirect_valid,
    input  redirect_pc, busy
  );

  modport slave (
    input  br_valid, br_target, br_ds_done, ds_valid,
    input  exc_valid, eret_valid, eret_target, redirect_ready,
    output commit_stall, flush_req, redirect_valid,
    output redirect_pc, busy
  );
endinterface

// File: rtl/commit_redirect_sequencer.sv
// Commit-stage recovery FSM: delay-slot wait, timed flush, single redirect.
// Optional REDIRECT_STATS_EN adds mispredict_cnt / exc_cnt counters.
module commit_redirect_sequencer #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380
) (
  input  logic clk,
  input  logic rst,
  commit_redirect_sequencer_if.slave rif
`ifdef REDIRECT_STATS_EN
  ,
  output logic [31:0] mispredict_cnt,
  output logic [31:0] exc_cnt
`endif
);

  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DS,
    FLUSH,
    REDIRECT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   tgt;
  logic [31:0]   tgt_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (rif.exc_valid) begin
          tgt_nxt   = EXC_VECTOR;
          state_nxt = FLUSH;
          cnt_nxt   = CNT_LOAD;
        end else if (rif.eret_valid) begin
          tgt_nxt   = rif.eret_target;
          state_nxt = FLUSH;
          cnt_nxt   = CNT_LOAD;
        end else if (rif.br_valid) begin
          tgt_nxt = rif.br_target;
          if (rif.br_ds_done) begin
            state_nxt = FLUSH;
            cnt_nxt   = CNT_LOAD;
          end else begin
            state_nxt = WAIT_DS;
          end
        end
      end
      WAIT_DS: begin
        if (rif.ds_valid) begin
          if (rif.exc_valid) tgt_nxt = EXC_VECTOR;
          state_nxt = FLUSH;
          cnt_nxt   = CNT_LOAD;
        end
      end
      FLUSH: begin
        if (cnt == '0) state_nxt = REDIRECT;
        else           cnt_nxt   = cnt - 1'b1;
      end
      REDIRECT: begin
        if (rif.redirect_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      tgt                <= '0;
      cnt                <= '0;
      rif.commit_stall   <= 1'b0;
      rif.flush_req      <= 1'b0;
      rif.redirect_valid <= 1'b0;
      rif.redirect_pc    <= '0;
      rif.busy           <= 1'b0;
    end else begin
      state              <= state_nxt;
      tgt                <= tgt_nxt;
      cnt                <= cnt_nxt;
      rif.commit_stall   <= (state_nxt == FLUSH) ||
                            (state_nxt == REDIRECT);
      rif.flush_req      <= (state_nxt == FLUSH);
      rif.redirect_valid <= (state_nxt == REDIRECT);
      rif.redirect_pc    <= (state_nxt == REDIRECT) ? tgt_nxt : '0;
      rif.busy           <= (state_nxt != IDLE);
    end
  end

`ifdef REDIRECT_STATS_EN
  logic br_acc;
  logic exc_acc;

  assign br_acc  = (state == IDLE) && rif.br_valid &&
                   !rif.exc_valid && !rif.eret_valid;
  assign exc_acc = rif.exc_valid &&
                   ((state == IDLE) ||
                    ((state == WAIT_DS) && rif.ds_valid));

  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict_cnt <= '0;
      exc_cnt        <= '0;
    end else begin
      if (br_acc)  mispredict_cnt <= mispredict_cnt + 32'd1;
      if (exc_acc) exc_cnt        <= exc_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_commit_redirect_sequencer.sv
// Directed vector bench for commit_redirect_sequencer (FLUSH_CYCLES=2).
module tb_commit_redirect_sequencer;

  localparam logic [31:0] EXC = 32'hBFC00380;
  localparam logic [31:0] TA  = 32'h80001000;
  localparam logic [31:0] TB  = 32'h80002000;
  localparam logic [31:0] TC  = 32'h80003000;
  localparam logic [31:0] TD  = 32'h80004000;
  localparam logic [31:0] TE  = 32'h80000200;
  localparam logic [31:0] TF  = 32'h80005000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  commit_redirect_sequencer_if rif ();

`ifdef REDIRECT_STATS_EN
  logic [31:0] mcnt;
  logic [31:0] ecnt;
`endif

  commit_redirect_sequencer #(
    .FLUSH_CYCLES(2),
    .EXC_VECTOR(32'hBFC00380)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rif(rif)
`ifdef REDIRECT_STATS_EN
    ,
    .mispredict_cnt(mcnt),
    .exc_cnt(ecnt)
`endif
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        br;
    logic        dsd;
    logic [31:0] bt;
    logic        ds;
    logic        exc;
    logic        eret;
    logic [31:0] et;
    logic        rdy;
    logic        st;
    logic        fl;
    logic        rv;
    logic [31:0] pc;
    logic        bz;
  } vec_t;

  vec_t vq[$];
  int   passed = 0;
  int   total  = 0;

  always @(posedge clk) begin
    if (!rst && rif.commit_stall)
      assert (!(rif.br_valid || rif.exc_valid ||
                rif.eret_valid || rif.ds_valid))
        else $error("retire event while commit is stalled");
  end

  task automatic add(string n, logic r, logic br, logic dsd,
                     logic [31:0] bt, logic ds, logic exc,
                     logic eret, logic [31:0] et, logic rdy,
                     logic st, logic fl, logic rv,
                     logic [31:0] pc, logic bz);
    vec_t v;
    v.name = n; v.rst = r; v.br = br; v.dsd = dsd; v.bt = bt;
    v.ds = ds; v.exc = exc; v.eret = eret; v.et = et;
    v.rdy = rdy; v.st = st; v.fl = fl; v.rv = rv; v.pc = pc;
    v.bz = bz;
    vq.push_back(v);
  endtask

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", n, act, exp);
    else
      passed++;
  endtask

  task automatic drive(vec_t v);
    rst                = v.rst;
    rif.br_valid       = v.br;
    rif.br_ds_done     = v.dsd;
    rif.br_target      = v.bt;
    rif.ds_valid       = v.ds;
    rif.exc_valid      = v.exc;
    rif.eret_valid     = v.eret;
    rif.eret_target    = v.et;
    rif.redirect_ready = v.rdy;
  endtask

  task automatic quiet(logic rdy);
    vec_t v;
    v.rst = 0; v.br = 0; v.dsd = 0; v.bt = 0; v.ds = 0;
    v.exc = 0; v.eret = 0; v.et = 0; v.rdy = rdy;
    drive(v);
  endtask

  initial begin
    int fl_cnt;
    int lat;
    bit got;
    rst = 1'b1;
    quiet(1'b1);

    add("rst",     1,0,0,0, 0,0,0,0, 1,  0,0,0,0,   0);
    add("idle",    0,0,0,0, 0,0,0,0, 1,  0,0,0,0,   0);
    add("a_ev",    0,1,1,TA,0,0,0,0, 1,  1,1,0,0,   1);
    add("a_fl2",   0,0,0,0, 0,0,0,0, 1,  1,1,0,0,   1);
    add("a_rd",    0,0,0,0, 0,0,0,0, 1,  1,0,1,TA,  1);
    add("a_idle",  0,0,0,0, 0,0,0,0, 1,  0,0,0,0,   0);
    add("b_ev",    0,1,0,TB,0,0,0,0, 1,  0,0,0,0,   1);
    add("b_w1",    0,0,0,0, 0,0,0,0, 1,  0,0,0,0,   1);
    add("b_wexc",  0,0,0,0, 0,1,0,0, 1,  0,0,0,0,   1);
    add("b_ds",    0,0,0,0, 1,0,0,0, 1,  1,1,0,0,   1);
    add("b_fl2",   0,0,0,0, 0,0,0,0, 1,  1,1,0,0,   1);
    add("b_rd",    0,0,0,0, 0,0,0,0, 1,  1,0,1,TB,  1);
    add("b_idle",  0,0,0,0, 0,0,0,0, 1,  0,0,0,0,   0);
    add("c_ev",    0,1,0,TC,0,0,0,0, 1,  0,0,0,0,   1);
    add("c_ign",   0,1,0,TD,0,0,1,TE,1,  0,0,0,0,   1);
    add("c_dsx",   0,0,0,0, 1,1,0,0, 1,  1,1,0,0,   1);
    add("c_fl2",   0,0,0,0, 0,0,0,0, 1,  1,1,0,0,   1);
    add("c_rd",    0,0,0,0, 0,0,0,0, 1,  1,0,1,EXC, 1);
    add("c_idle",  0,0,0,0, 0,0,0,0, 1,  0,0,0,0,   0);
    add("d_ev",    0,1,1,TA,0,1,1,TE,1,  1,1,0,0,   1);
    add("d_fl2",   0,0,0,0, 0,0,0,0, 1,  1,1,0,0,   1);
    add("d_rd",    0,0,0,0, 0,0,0,0, 1,  1,0,1,EXC, 1);
    add("d_idle",  0,0,0,0, 0,0,0,0, 1,  0,0,0,0,   0);
    add("e_ev",    0,1,0,TD,0,0,1,TE,1,  1,1,0,0,   1);
    add("e_fl2",   0,0,0,0, 0,0,0,0, 1,  1,1,0,0,   1);
    add("e_rd",    0,0,0,0, 0,0,0,0, 1,  1,0,1,TE,  1);
    add("e_idle",  0,0,0,0, 0,0,0,0, 1,  0,0,0,0,   0);
    add("f_ev",    0,1,1,TF,0,0,0,0, 0,  1,1,0,0,   1);
    add("f_fl2",   0,0,0,0, 0,0,0,0, 0,  1,1,0,0,   1);
    add("f_rd",    0,0,0,0, 0,0,0,0, 0,  1,0,1,TF,  1);
    for (int i = 0; i < 4; i++)
      add("f_hold",0,0,0,0, 0,0,0,0, 0,  1,0,1,TF,  1);
    add("f_acc",   0,0,0,0, 0,0,0,0, 1,  0,0,0,0,   0);
    add("g_ev",    0,1,1,TA,0,0,0,0, 1,  1,1,0,0,   1);
    add("g_fl2",   0,0,0,0, 0,0,0,0, 1,  1,1,0,0,   1);
    add("g_rst",   1,0,0,0, 0,0,0,0, 1,  0,0,0,0,   0);
    for (int i = 0; i < 3; i++)
      add("g_quiet",0,0,0,0,0,0,0,0, 1,  0,0,0,0,   0);

    foreach (vq[i]) begin
      drive(vq[i]);
      @(posedge clk);
      #1;
      chk({vq[i].name, ".stall"}, 32'(rif.commit_stall), 32'(vq[i].st));
      chk({vq[i].name, ".flush"}, 32'(rif.flush_req), 32'(vq[i].fl));
      chk({vq[i].name, ".rvalid"}, 32'(rif.redirect_valid),
          32'(vq[i].rv));
      chk({vq[i].name, ".rpc"}, rif.redirect_pc, vq[i].pc);
      chk({vq[i].name, ".busy"}, 32'(rif.busy), 32'(vq[i].bz));
    end

    // Latency sequence: exception, count flush cycles until redirect.
    quiet(1'b1);
    rif.exc_valid = 1'b1;
    @(posedge clk);
    #1;
    quiet(1'b1);
    fl_cnt = 0;
    lat    = 0;
    got    = 0;
    for (int i = 0; i < 20; i++) begin
      if (rif.flush_req) fl_cnt++;
      if (rif.redirect_valid) begin
        got = 1;
        lat = i;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("lat.seen", 32'(got), 32'd1);
    chk("lat.flush_cycles", fl_cnt, 2);
    chk("lat.redirect_cycle", lat, 2);
    chk("lat.pc", rif.redirect_pc, EXC);
    @(posedge clk);
    #1;
    chk("lat.back_idle", 32'(rif.busy), 32'd0);

`ifdef REDIRECT_STATS_EN
    rst = 1'b1;
    @(posedge clk);
    #1;
    quiet(1'b1);
    rif.br_valid  = 1'b1;
    rif.br_target = TC;
    @(posedge clk);
    #1;
    quiet(1'b1);
    rif.ds_valid  = 1'b1;
    rif.exc_valid = 1'b1;
    @(posedge clk);
    #1;
    quiet(1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
    end
    chk("stats.mispredict", mcnt, 32'd1);
    chk("stats.exc", ecnt, 32'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
